// File: rtl/usb_pkt_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkt_pkg
// Shared types and helpers for the USB word packetizer.
//   BYTE_W            : width of one USB byte lane
//   tx_state_t        : TX FSM encoding (CHK only reached with USB_PKT_CHECKSUM_EN)
//   xor_reduce_bytes  : XOR of the low nbytes bytes of a 64-bit value
// -----------------------------------------------------------------------------
package usb_pkt_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      CHK  = 2'd2
   } tx_state_t;

   function automatic logic [BYTE_W-1:0] xor_reduce_bytes(input logic [63:0] data,
                                                          input int unsigned nbytes);
      logic [BYTE_W-1:0] acc;
      acc = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < nbytes) acc = acc ^ data[i*BYTE_W +: BYTE_W];
      end
      return acc;
   endfunction

endpackage

// File: rtl/usb_word_packetizer_if.sv
// -----------------------------------------------------------------------------
// usb_word_packetizer_if
// Word-side and byte-side signals of the USB word packetizer.
//   slave  : the packetizer itself
//   master : the environment (averaging datapath + USB byte layer)
// Word side : output_ready, average_data, tx_busy, stock_data, data_ready, rx_error
// Byte TX   : tx_data, tx_valid, tx_ready, tx_new_packet
// Byte RX   : rx_data, rx_valid, rx_new_packet
// -----------------------------------------------------------------------------
interface usb_word_packetizer_if #(
   parameter int unsigned WORD_BYTES = 4
);
   localparam int unsigned W = WORD_BYTES * 8;

   logic         output_ready;
   logic [W-1:0] average_data;
   logic         tx_busy;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic         tx_new_packet;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic         rx_new_packet;
   logic [W-1:0] stock_data;
   logic         data_ready;
   logic         rx_error;

   modport slave (
      input  output_ready, average_data, tx_ready, rx_data, rx_valid, rx_new_packet,
      output tx_busy, tx_data, tx_valid, tx_new_packet, stock_data, data_ready, rx_error
   );

   modport master (
      output output_ready, average_data, tx_ready, rx_data, rx_valid, rx_new_packet,
      input  tx_busy, tx_data, tx_valid, tx_new_packet, stock_data, data_ready, rx_error
   );

endinterface

// File: rtl/usb_byte_shifter.sv
// -----------------------------------------------------------------------------
// usb_byte_shifter
// W-bit load / shift-by-one-byte register presenting the current byte.
//   clk_i, n_rst_i : clock, async active-low reset
//   load_i, data_i : parallel load (has priority over shift)
//   shift_i        : drop the current byte, expose the next one
//   byte_o         : current byte (low byte if LSB_FIRST!=0, else high byte)
// -----------------------------------------------------------------------------
module usb_byte_shifter
   import usb_pkt_pkg::*;
#(
   parameter int unsigned W         = 32,
   parameter int unsigned LSB_FIRST = 1
) (
   input  logic              clk_i,
   input  logic              n_rst_i,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [W-1:0]      data_i,
   output logic [BYTE_W-1:0] byte_o
);

   logic [W-1:0] sh_q, sh_d;

   always_comb begin
      sh_d = sh_q;
      if (load_i) begin
         sh_d = data_i;
      end else if (shift_i) begin
         sh_d = (LSB_FIRST != 0) ? (sh_q >> BYTE_W) : (sh_q << BYTE_W);
      end
   end

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) sh_q <= '0;
      else          sh_q <= sh_d;
   end

   assign byte_o = (LSB_FIRST != 0) ? sh_q[BYTE_W-1:0] : sh_q[W-1 -: BYTE_W];

endmodule

// File: rtl/usb_word_packetizer.sv
// -----------------------------------------------------------------------------
// usb_word_packetizer
// Bridges WORD_BYTES-wide words and the byte-level USB packet layer.
//   clk, n_rst : clock (rising edge), asynchronous active-low reset
//   bus        : usb_word_packetizer_if.slave
//     TX: output_ready/average_data load a word (only while tx_busy=0); it is
//         sent as WORD_BYTES bytes on tx_data/tx_valid/tx_ready, the first one
//         flagged with tx_new_packet.
//     RX: rx_data/rx_valid/rx_new_packet bytes are assembled into stock_data;
//         data_ready pulses on a complete word, rx_error on framing errors.
// Optional build macro USB_PKT_CHECKSUM_EN: one extra XOR checksum byte per
// word in both directions; a bad RX checksum raises rx_error instead of
// data_ready.
// -----------------------------------------------------------------------------
module usb_word_packetizer
   import usb_pkt_pkg::*;
#(
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned LSB_FIRST  = 1
) (
   input  logic                  clk,
   input  logic                  n_rst,
   usb_word_packetizer_if.slave  bus
);

   localparam int unsigned W     = WORD_BYTES * BYTE_W;
   localparam int unsigned CNT_W = 4;

   // ---------------------------------------------------------------- TX path
   tx_state_t          state_q, state_d;
   logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
   logic               sh_load, sh_shift;
   logic [BYTE_W-1:0]  sh_byte;
`ifdef USB_PKT_CHECKSUM_EN
   logic [BYTE_W-1:0]  chk_q, chk_d;
`endif

   usb_byte_shifter #(
      .W         (W),
      .LSB_FIRST (LSB_FIRST)
   ) u_tx_shifter (
      .clk_i   (clk),
      .n_rst_i (n_rst),
      .load_i  (sh_load),
      .shift_i (sh_shift),
      .data_i  (bus.average_data),
      .byte_o  (sh_byte)
   );

   always_comb begin
      state_d  = state_q;
      tx_cnt_d = tx_cnt_q;
      sh_load  = 1'b0;
      sh_shift = 1'b0;
`ifdef USB_PKT_CHECKSUM_EN
      chk_d    = chk_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.output_ready) begin
               sh_load  = 1'b1;
               tx_cnt_d = '0;
               state_d  = SEND;
`ifdef USB_PKT_CHECKSUM_EN
               chk_d    = xor_reduce_bytes(64'(bus.average_data), WORD_BYTES);
`endif
            end
         end
         SEND: begin
            if (bus.tx_ready) begin
               sh_shift = 1'b1;
               if (tx_cnt_q == CNT_W'(WORD_BYTES - 1)) begin
                  tx_cnt_d = '0;
`ifdef USB_PKT_CHECKSUM_EN
                  state_d  = CHK;
`else
                  state_d  = IDLE;
`endif
               end else begin
                  tx_cnt_d = tx_cnt_q + CNT_W'(1);
               end
            end
         end
`ifdef USB_PKT_CHECKSUM_EN
         CHK: begin
            if (bus.tx_ready) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         tx_cnt_q <= '0;
`ifdef USB_PKT_CHECKSUM_EN
         chk_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         tx_cnt_q <= tx_cnt_d;
`ifdef USB_PKT_CHECKSUM_EN
         chk_q    <= chk_d;
`endif
      end
   end

   // Outputs decode the registered state only, so reset clears them at once.
   assign bus.tx_valid      = (state_q != IDLE);
   assign bus.tx_busy       = (state_q != IDLE);
   assign bus.tx_new_packet = (state_q == SEND) && (tx_cnt_q == '0);
`ifdef USB_PKT_CHECKSUM_EN
   assign bus.tx_data = (state_q == SEND) ? sh_byte :
                        ((state_q == CHK) ? chk_q : '0);
`else
   assign bus.tx_data = (state_q == SEND) ? sh_byte : '0;
`endif

   // ---------------------------------------------------------------- RX path
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, rx_pos;
   logic [W-1:0]     asm_q, asm_d, rx_placed;
   logic [W-1:0]     stock_q, stock_d;
   logic             ready_q, ready_d;
   logic             err_q, err_d;

   // A new-packet byte restarts from an empty word at position 0, which is
   // what discards any partial word in progress.
   always_comb begin
      rx_pos    = bus.rx_new_packet ? '0 : rx_cnt_q;
      rx_placed = bus.rx_new_packet ? '0 : asm_q;
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
         if (rx_pos == CNT_W'(i)) begin
            rx_placed[((LSB_FIRST != 0) ? i : (WORD_BYTES - 1 - i))*BYTE_W +: BYTE_W] = bus.rx_data;
         end
      end
   end

   always_comb begin
      rx_cnt_d = rx_cnt_q;
      asm_d    = asm_q;
      stock_d  = stock_q;
      ready_d  = 1'b0;
      err_d    = 1'b0;
      if (bus.rx_valid) begin
         if (bus.rx_new_packet) err_d = (rx_cnt_q != '0);
         else if (rx_cnt_q == '0) err_d = 1'b1;

         if (bus.rx_new_packet || (rx_cnt_q != '0)) begin
`ifdef USB_PKT_CHECKSUM_EN
            if (rx_pos == CNT_W'(WORD_BYTES)) begin
               rx_cnt_d = '0;
               if (bus.rx_data == xor_reduce_bytes(64'(asm_q), WORD_BYTES)) begin
                  stock_d = asm_q;
                  ready_d = 1'b1;
               end else begin
                  err_d   = 1'b1;
               end
            end else begin
               asm_d    = rx_placed;
               rx_cnt_d = rx_pos + CNT_W'(1);
            end
`else
            asm_d = rx_placed;
            if (rx_pos == CNT_W'(WORD_BYTES - 1)) begin
               stock_d  = rx_placed;
               ready_d  = 1'b1;
               rx_cnt_d = '0;
            end else begin
               rx_cnt_d = rx_pos + CNT_W'(1);
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rx_cnt_q <= '0;
         asm_q    <= '0;
         stock_q  <= '0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rx_cnt_q <= rx_cnt_d;
         asm_q    <= asm_d;
         stock_q  <= stock_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
      end
   end

   assign bus.stock_data = stock_q;
   assign bus.data_ready = ready_q;
   assign bus.rx_error   = err_q;

endmodule

// File: tb/tb_usb_word_packetizer.sv
// -----------------------------------------------------------------------------
// tb_usb_word_packetizer
// Directed and randomized stimulus for usb_word_packetizer, checked every
// cycle against a queue-based reference model of the byte streams.
// Honours USB_PKT_CHECKSUM_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_usb_word_packetizer;

   localparam int unsigned WB   = 4;
   localparam int unsigned LSBF = 1;
   localparam int unsigned W    = WB * 8;
`ifdef USB_PKT_CHECKSUM_EN
   localparam int unsigned FRAME_LEN = WB + 1;
`else
   localparam int unsigned FRAME_LEN = WB;
`endif

   typedef struct packed {
      logic       np;
      logic [7:0] b;
   } beat_t;

   logic clk;
   logic n_rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   chk_en   = 1'b0;

   // reference model state
   beat_t        txq[$];
   logic [7:0]   rxf[$];
   logic [W-1:0] m_stock = '0;
   bit           m_ready = 1'b0;
   bit           m_err   = 1'b0;

   usb_word_packetizer_if #(.WORD_BYTES(WB)) bus ();

   usb_word_packetizer #(
      .WORD_BYTES (WB),
      .LSB_FIRST  (LSBF)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // byte i of a word on the wire: position i maps to bits [lane*8 +: 8]
   function automatic int unsigned lane_of(input int unsigned i);
      return (LSBF != 0) ? i : (WB - 1 - i);
   endfunction

   function automatic logic [7:0] byte_of(input logic [W-1:0] w, input int unsigned i);
      return 8'(w >> (lane_of(i) * 8));
   endfunction

`ifdef USB_PKT_CHECKSUM_EN
   function automatic logic [7:0] xor_of(input logic [W-1:0] w);
      logic [7:0] x;
      x = '0;
      for (int unsigned i = 0; i < WB; i++) x = x ^ byte_of(w, i);
      return x;
   endfunction
`endif

   // ------------------------------------------------------ reference model
   task automatic model_step();
      logic [W-1:0] word;
      beat_t        bt;
      if (!n_rst) begin
         txq.delete();
         rxf.delete();
         m_stock = '0;
         m_ready = 1'b0;
         m_err   = 1'b0;
         return;
      end
      // TX: a word in flight consumes beats; only an idle sender takes a word
      if (txq.size() != 0) begin
         if (bus.tx_ready) void'(txq.pop_front());
      end else if (bus.output_ready) begin
         for (int unsigned i = 0; i < WB; i++) begin
            bt.np = (i == 0);
            bt.b  = byte_of(bus.average_data, i);
            txq.push_back(bt);
         end
`ifdef USB_PKT_CHECKSUM_EN
         bt.np = 1'b0;
         bt.b  = xor_of(bus.average_data);
         txq.push_back(bt);
`endif
      end
      // RX
      m_ready = 1'b0;
      m_err   = 1'b0;
      if (bus.rx_valid) begin
         if (bus.rx_new_packet) begin
            if (rxf.size() != 0) m_err = 1'b1;
            rxf.delete();
            rxf.push_back(bus.rx_data);
         end else if (rxf.size() == 0) begin
            m_err = 1'b1;
         end else begin
            rxf.push_back(bus.rx_data);
         end
         if (rxf.size() == FRAME_LEN) begin
            word = '0;
            for (int unsigned i = 0; i < WB; i++) word = word | (W'(rxf[i]) << (lane_of(i) * 8));
`ifdef USB_PKT_CHECKSUM_EN
            if (rxf[WB] == xor_of(word)) begin
               m_stock = word;
               m_ready = 1'b1;
            end else begin
               m_err = 1'b1;
            end
`else
            m_stock = word;
            m_ready = 1'b1;
`endif
            rxf.delete();
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge n_rst);
      model_step();
   end

   // ------------------------------------------------------ per-cycle checker
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check_eq("tx_valid", bus.tx_valid, txq.size() != 0);
         check_eq("tx_busy",  bus.tx_busy,  txq.size() != 0);
         if (txq.size() != 0) begin
            check_eq("tx_data",       bus.tx_data,       txq[0].b);
            check_eq("tx_new_packet", bus.tx_new_packet, txq[0].np);
         end else begin
            check_eq("tx_new_packet_idle", bus.tx_new_packet, 0);
         end
         check_eq("data_ready", bus.data_ready, m_ready);
         check_eq("rx_error",   bus.rx_error,   m_err);
         check_eq("stock_data", bus.stock_data, m_stock);
      end
   end

   // ------------------------------------------------------ stimulus helpers
   // All helpers are entered and left on a falling clock edge.
   task automatic tx_start(input logic [W-1:0] w);
      bus.output_ready = 1'b1;
      bus.average_data = w;
      @(negedge clk);
      bus.output_ready = 1'b0;
   endtask

   task automatic wait_tx_idle(input int unsigned budget);
      int unsigned k;
      k = 0;
      while ((txq.size() != 0) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      check_eq("tx_drain_busy", bus.tx_busy, 0);
   endtask

   task automatic rx_send(input logic [7:0] b, input bit np);
      bus.rx_valid      = 1'b1;
      bus.rx_data       = b;
      bus.rx_new_packet = np;
      @(negedge clk);
      bus.rx_valid      = 1'b0;
      bus.rx_new_packet = 1'b0;
   endtask

   task automatic rx_data_bytes(input logic [W-1:0] w, input bit gaps);
      for (int unsigned i = 0; i < WB; i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk);
         rx_send(byte_of(w, i), i == 0);
      end
   endtask

   task automatic rx_word(input logic [W-1:0] w, input bit gaps);
      rx_data_bytes(w, gaps);
`ifdef USB_PKT_CHECKSUM_EN
      rx_send(xor_of(w), 1'b0);
`endif
   endtask

   // ------------------------------------------------------ watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not complete, %0d checks, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------ main sequence
   initial begin
      int unsigned mode;
      n_rst             = 1'b1;
      bus.output_ready  = 1'b0;
      bus.average_data  = '0;
      bus.tx_ready      = 1'b0;
      bus.rx_data       = '0;
      bus.rx_valid      = 1'b0;
      bus.rx_new_packet = 1'b0;
      #1 n_rst = 1'b0;
      #1;
      check_eq("rst_tx_valid",      bus.tx_valid,      0);
      check_eq("rst_tx_busy",       bus.tx_busy,       0);
      check_eq("rst_tx_data",       bus.tx_data,       0);
      check_eq("rst_tx_new_packet", bus.tx_new_packet, 0);
      check_eq("rst_stock_data",    bus.stock_data,    0);
      check_eq("rst_data_ready",    bus.data_ready,    0);
      check_eq("rst_rx_error",      bus.rx_error,      0);
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      // TX, sink always ready
      bus.tx_ready = 1'b1;
      tx_start(W'(64'hDEADBEEF));
      wait_tx_idle(20);

      // TX backpressure on the third byte, plus an ignored request mid-word
      tx_start(W'(64'hDEADBEEF));
      @(negedge clk);
      @(negedge clk);
      bus.tx_ready = 1'b0;
      @(negedge clk);
      bus.output_ready = 1'b1;
      bus.average_data = W'(64'h12345678);
      @(negedge clk);
      bus.output_ready = 1'b0;
      @(negedge clk);
      bus.tx_ready = 1'b1;
      wait_tx_idle(20);

      // RX good word
      rx_word(W'(64'h44332211), 1'b0);
      repeat (2) @(negedge clk);

      // RX framing: truncated word, restart, then a stray byte
      rx_send(8'h11, 1'b1);
      rx_send(8'h22, 1'b0);
      rx_word(W'(64'h88776655), 1'b0);
      repeat (2) @(negedge clk);
      rx_send(8'h99, 1'b0);
      repeat (2) @(negedge clk);

      // async reset in the middle of a TX word
      tx_start(W'(64'hCAFEF00D));
      @(negedge clk);
      #1 n_rst = 1'b0;
      #1;
      check_eq("arst_tx_valid",   bus.tx_valid,   0);
      check_eq("arst_tx_busy",    bus.tx_busy,    0);
      check_eq("arst_stock_data", bus.stock_data, 0);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      rx_word(W'(64'h44332211), 1'b0);
      repeat (2) @(negedge clk);

`ifdef USB_PKT_CHECKSUM_EN
      tx_start(W'(64'h01020304));
      wait_tx_idle(20);
      rx_data_bytes(W'(64'h01020304), 1'b0);
      rx_send(8'h00, 1'b0);
      repeat (2) @(negedge clk);
`endif

      // randomized concurrent traffic
      fork
         begin
            for (int c = 0; c < 400; c++) begin
               bus.output_ready = ($urandom_range(0, 2) == 0);
               bus.average_data = W'({$urandom(), $urandom()});
               bus.tx_ready     = ($urandom_range(0, 3) != 0);
               @(negedge clk);
            end
            bus.output_ready = 1'b0;
            bus.tx_ready     = 1'b1;
         end
         begin
            for (int f = 0; f < 60; f++) begin
               mode = $urandom_range(0, 9);
               if (mode < 6) begin
                  rx_word(W'({$urandom(), $urandom()}), 1'b1);
               end else if (mode == 6) begin
`ifdef USB_PKT_CHECKSUM_EN
                  rx_data_bytes(W'(64'h0F1E2D3C4B5A6978), 1'b1);
                  rx_send(~xor_of(W'(64'h0F1E2D3C4B5A6978)), 1'b0);
`else
                  rx_word(W'({$urandom(), $urandom()}), 1'b0);
`endif
               end else if (mode == 7) begin
                  rx_send(8'($urandom()), 1'b1);
                  rx_send(8'($urandom()), 1'b0);
               end else if (mode == 8) begin
                  rx_send(8'($urandom()), 1'b0);
               end else begin
                  @(negedge clk);
               end
            end
         end
      join
      wait_tx_idle(50);
      repeat (4) @(negedge clk);
      chk_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
